dec_scan: RTL and testbench
===========================

DEC_SCAN -- requirements
Module: dec_scan

Interface
REQ-001 SHALL have parameter N, default 2, meaning address width; output width is 2**N; legal range 1..6.
REQ-002 SHALL have parameter DWELL, default 4, meaning clock cycles each channel is held in scan mode; legal range 1..255.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset; synchronous, active-low.
REQ-005 SHALL have port E, input, 1, meaning decoder enable.
REQ-006 SHALL have port mode, input, 1, meaning mode select: 0 = direct decode, 1 = auto-scan.
REQ-007 SHALL have port A, input, N, meaning the address (direct mode) or the start channel (scan mode).
REQ-008 SHALL have port Y, output, 2**N, meaning registered one-hot select.
REQ-009 SHALL have port idx, output, N, meaning the registered index of the channel currently asserted on Y.
REQ-010 SHALL have port wrap, output, 1, meaning a scan wrap pulse; present only under the configuration macro.

Function
REQ-011 SHALL implement FSM states OFF, DIRECT and SCAN.
REQ-012 SHALL move to OFF on the next edge when E=0, from any state.
REQ-013 SHALL move to DIRECT when E=1 and mode=0.
REQ-014 SHALL move to SCAN when E=1 and mode=1.
REQ-015 In OFF, SHALL drive Y=0; idx holds its last value.
REQ-016 In DIRECT, SHALL register Y=1<<A and idx=A with one-cycle latency; A changes track every cycle.
REQ-017 On any entry into SCAN (from OFF or DIRECT), SHALL load idx=A and Y=1<<A, and clear the dwell counter.
REQ-018 In SCAN, SHALL hold idx for exactly DWELL cycles, then set idx=idx+1 modulo 2**N; Y follows idx on the same edge.
REQ-019 In SCAN, SHALL ignore A except at entry.
REQ-020 SHALL advance idx every cycle when DWELL=1.
REQ-021 SHALL wrap idx from 2**N-1 to 0.
REQ-022 On a mode change mid-dwell, SHALL take the new state on the next edge and discard the partial dwell.
REQ-023 SHALL keep Y either all-zero or exactly one-hot at all times.
REQ-024 SHALL size the dwell counter at ceil(log2(DWELL+1)) bits, with no overflow path.

Reset
REQ-025 While rst_n=0 at a clock edge, SHALL set state=OFF, Y=0, idx=0, dwell counter=0 and wrap=0.
REQ-026 rst_n SHALL dominate E and mode.
REQ-027 Reset mid-scan SHALL abort the scan; after release with E=1 and mode=1, scan SHALL restart at A per REQ-017.

Configuration
REQ-028 Macro DEC_SCAN_WRAP_EN SHALL control the wrap feature.
- Defined: port wrap exists and pulses high for exactly one cycle, coincident with the edge where idx goes from 2**N-1 to 0 in SCAN. It never pulses in DIRECT or OFF, or on SCAN entry.
- Undefined: port wrap and its logic are absent; all other behaviour is identical.

Structure
REQ-029 A shared package dec_pkg SHALL hold the FSM state enum (OFF, DIRECT, SCAN) and the constant DEC_DWELL_DEFAULT=4.
REQ-030 The combinational index-to-one-hot decode SHALL be one sub-module, dec_onehot, parameterised by N; the registers live in dec_scan.
REQ-031 The implementation SHALL be 120-400 lines of RTL total.

Verification
REQ-032 The bench SHALL use N=2, DWELL=3 unless stated otherwise, and SHALL cover these scenarios:
- Reset: rst_n=0 for 2 cycles with E=1, mode=1 -> Y=4'b0000, idx=0, wrap=0; after release, Y=4'b0001 one cycle later when A=0.
- Direct: E=1, mode=0, A stepping 0,1,2,3 on consecutive cycles -> Y = 0001, 0010, 0100, 1000, each one cycle after its A.
- Scan: E=1, mode=1, A=2 at entry -> Y=0100 for 3 cycles, then 1000 for 3, then 0001 (wrap pulses with DEC_SCAN_WRAP_EN), then 0010.
- Disable mid-scan: E drops during dwell cycle 2 of idx=1 -> Y=0000 next cycle with idx held at 1; E=1 again with A=3 -> Y=1000 and a full 3-cycle dwell.
- Mode switch: SCAN at idx=3, dwell cycle 1, switch to mode=0 with A=1 -> Y=0010 next cycle, no wrap pulse; then back to mode=1 -> scan restarts at A.
- DWELL=1 with N=3: scan from A=6 -> idx 6, 7, 0, 1 on consecutive cycles, with a single wrap pulse on the 7->0 edge; one-hot property asserted on every cycle.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared types for the scanning decoder: FSM state encoding and default dwell.
package dec_pkg;

  typedef enum logic [1:0] {
    OFF,
    DIRECT,
    SCAN
  } dec_state_t;

  localparam int DEC_DWELL_DEFAULT = 4;

endpackage

// File: rtl/dec_onehot.sv
// Combinational index to one-hot decode.
module dec_onehot #(
  parameter int N = 2
) (
  input  logic [N-1:0]    a,
  output logic [2**N-1:0] y
);

  always_comb begin
    y    = '0;
    y[a] = 1'b1;
  end

endmodule

// File: rtl/dec_scan.sv
// Registered one-hot decoder with direct and auto-scan modes.
// Optional scan wrap pulse output enabled by DEC_SCAN_WRAP_EN.
module dec_scan
  import dec_pkg::*;
#(
  parameter int N     = 2,
  parameter int DWELL = DEC_DWELL_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            E,
  input  logic            mode,
  input  logic [N-1:0]    A,
  output logic [2**N-1:0] Y,
  output logic [N-1:0]    idx
`ifdef DEC_SCAN_WRAP_EN
  ,
  output logic            wrap
`endif
);

  localparam int CW = $clog2(DWELL + 1);
  localparam int M  = 2**N;

  dec_state_t       state;
  logic [CW-1:0]    cnt;
  logic [N-1:0]     nxt_idx;
  logic [M-1:0]     nxt_y;
  logic             entry;
  logic             last;

  assign entry = (state != SCAN);
  assign last  = (cnt == CW'(DWELL - 1));

  // A is only honoured outside a running scan.
  always_comb begin
    nxt_idx = A;
    if (mode && !entry) begin
      if (last) nxt_idx = idx + 1'b1;
      else      nxt_idx = idx;
    end
  end

  dec_onehot #(
    .N(N)
  ) u_onehot (
    .a(nxt_idx),
    .y(nxt_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= OFF;
      Y     <= '0;
      idx   <= '0;
      cnt   <= '0;
`ifdef DEC_SCAN_WRAP_EN
      wrap  <= 1'b0;
`endif
    end else if (!E) begin
      state <= OFF;
      Y     <= '0;
      cnt   <= '0;
`ifdef DEC_SCAN_WRAP_EN
      wrap  <= 1'b0;
`endif
    end else if (!mode) begin
      state <= DIRECT;
      Y     <= nxt_y;
      idx   <= nxt_idx;
      cnt   <= '0;
`ifdef DEC_SCAN_WRAP_EN
      wrap  <= 1'b0;
`endif
    end else begin
      state <= SCAN;
      Y     <= nxt_y;
      idx   <= nxt_idx;
      cnt   <= (entry || last) ? '0 : cnt + 1'b1;
`ifdef DEC_SCAN_WRAP_EN
      wrap  <= !entry && last && (idx == N'(M - 1));
`endif
    end
  end

endmodule

// File: tb/tb_dec_scan.sv
// Self-checking bench for dec_scan: directed scenarios plus randomized
// traffic against a time-based reference model (N=2/DWELL=3, N=3/DWELL=1).
module tb_dec_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       e0, m0, e1, m1;
  logic [1:0] a0, i0;
  logic [3:0] y0;
  logic [2:0] a1, i1;
  logic [7:0] y1;
  logic       w0, w1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dec_scan #(.N(2), .DWELL(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .E(e0), .mode(m0),
    .A(a0), .Y(y0), .idx(i0)
`ifdef DEC_SCAN_WRAP_EN
    , .wrap(w0)
`endif
  );

  dec_scan #(.N(3), .DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .E(e1), .mode(m1),
    .A(a1), .Y(y1), .idx(i1)
`ifdef DEC_SCAN_WRAP_EN
    , .wrap(w1)
`endif
  );

`ifndef DEC_SCAN_WRAP_EN
  assign w0 = 1'b0;
  assign w1 = 1'b0;
`endif

  // Model: 0=off 1=direct 2=scan; scan index derived from entry start and age.
  int md_state[2] = '{0, 0};
  int md_idx[2]   = '{0, 0};
  int md_start[2] = '{0, 0};
  int md_age[2]   = '{0, 0};
  bit md_wrap[2]  = '{0, 0};
  int mm[2]       = '{4, 8};
  int dw[2]       = '{3, 1};

  task automatic model_edge(int k, bit rst, bit e, bit m, int a);
    int prev;
    bit was_scan;
    prev       = md_idx[k];
    was_scan   = (md_state[k] == 2);
    md_wrap[k] = 1'b0;
    if (!rst) begin
      md_state[k] = 0;
      md_idx[k]   = 0;
    end else if (!e) begin
      md_state[k] = 0;
    end else if (!m) begin
      md_state[k] = 1;
      md_idx[k]   = a;
    end else begin
      if (was_scan) md_age[k]++;
      else begin
        md_start[k] = a;
        md_age[k]   = 0;
      end
      md_state[k] = 2;
      md_idx[k]   = (md_start[k] + md_age[k] / dw[k]) % mm[k];
      md_wrap[k]  = was_scan && prev == mm[k] - 1 && md_idx[k] == 0;
    end
  endtask

  function automatic logic [31:0] exp_y(int k);
    return (md_state[k] == 0) ? 32'd0 : (32'd1 << md_idx[k]);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, rst_n, e0, m0, int'(a0));
    model_edge(1, rst_n, e1, m1, int'(a1));
    #1;
    chk("y0", 32'(y0), exp_y(0));
    chk("idx0", 32'(i0), 32'(md_idx[0]));
    chk("onehot0", 32'($onehot0(y0)), 32'd1);
    chk("y1", 32'(y1), exp_y(1));
    chk("idx1", 32'(i1), 32'(md_idx[1]));
    chk("onehot1", 32'($onehot0(y1)), 32'd1);
`ifdef DEC_SCAN_WRAP_EN
    chk("wrap0", 32'(w0), 32'(md_wrap[0]));
    chk("wrap1", 32'(w1), 32'(md_wrap[1]));
`endif
  endtask

  logic [3:0] scan_exp[11] = '{4'b0100, 4'b0100, 4'b0100,
                               4'b1000, 4'b1000, 4'b1000,
                               4'b0001, 4'b0001, 4'b0001,
                               4'b0010, 4'b0010};

  initial begin
    rst_n = 1'b0;
    e0 = 1'b1; m0 = 1'b1; a0 = 2'd0;
    e1 = 1'b0; m1 = 1'b0; a1 = 3'd0;
    #2;

    // Reset dominates enable and mode
    step();
    step();
    chk("rst_y", 32'(y0), 32'h0);
    chk("rst_idx", 32'(i0), 32'h0);
    chk("rst_wrap", 32'(w0), 32'h0);
    rst_n = 1'b1;
    step();
    chk("rel_y", 32'(y0), 32'b0001);

    // Direct decode, one-cycle latency
    m0 = 1'b0;
    for (int a = 0; a < 4; a++) begin
      a0 = 2'(a);
      step();
      chk("dir_y", 32'(y0), 32'd1 << a);
    end

    // Scan from 2 with A ignored after entry
    m0 = 1'b1;
    a0 = 2'd2;
    for (int s = 0; s < 11; s++) begin
      step();
      a0 = 2'd1;
      chk("scan_y", 32'(y0), 32'(scan_exp[s]));
`ifdef DEC_SCAN_WRAP_EN
      chk("scan_wrap", 32'(w0), (s == 6) ? 32'd1 : 32'd0);
`endif
    end

    // Disable during dwell cycle 2 of idx 1
    e0 = 1'b0;
    step();
    chk("dis_y", 32'(y0), 32'h0);
    chk("dis_idx", 32'(i0), 32'd1);
    e0 = 1'b1;
    a0 = 2'd3;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("reen_y", 32'(y0), 32'b1000);
    end
    step();
    chk("reen_next", 32'(y0), 32'b0001);

    // Mode switch at idx 3 dwell cycle 1
    e0 = 1'b0;
    step();
    e0 = 1'b1;
    a0 = 2'd3;
    step();
    chk("ms_pre", 32'(y0), 32'b1000);
    m0 = 1'b0;
    a0 = 2'd1;
    step();
    chk("ms_y", 32'(y0), 32'b0010);
    chk("ms_wrap", 32'(w0), 32'h0);
    m0 = 1'b1;
    a0 = 2'd2;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("ms_rescan", 32'(y0), 32'b0100);
    end
    step();
    chk("ms_adv", 32'(y0), 32'b1000);

    // Randomized traffic on the DWELL=3 instance
    for (int r = 0; r < 300; r++) begin
      rst_n = ($urandom_range(0, 40) != 0);
      e0    = ($urandom_range(0, 7) != 0);
      m0    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) a0 = 2'($urandom);
      step();
    end
    rst_n = 1'b1;
    e0 = 1'b0;
    step();

    // DWELL=1, N=3: advance every cycle, wrap 7->0
    e1 = 1'b1;
    m1 = 1'b1;
    a1 = 3'd6;
    step();
    chk("d1_i6", 32'(i1), 32'd6);
    a1 = 3'd2;
    step();
    chk("d1_i7", 32'(i1), 32'd7);
    chk("d1_w7", 32'(w1), 32'h0);
    step();
    chk("d1_i0", 32'(i1), 32'd0);
    chk("d1_y0", 32'(y1), 32'h01);
`ifdef DEC_SCAN_WRAP_EN
    chk("d1_wrap", 32'(w1), 32'd1);
`endif
    step();
    chk("d1_i1", 32'(i1), 32'd1);
    chk("d1_w1", 32'(w1), 32'h0);

    for (int r = 0; r < 300; r++) begin
      rst_n = ($urandom_range(0, 40) != 0);
      e1    = ($urandom_range(0, 7) != 0);
      m1    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) a1 = 3'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
